// File: rtl/gcd_euclid.sv
// gcd_euclid: multi-cycle GCD engine using Euclid's algorithm, with the
// modulo step done by repeated subtraction.
//
// Ports
//   clk    : single clock, all state updates on the rising edge
//   reset  : synchronous active-low reset
//   start  : request a computation; only sampled while idle
//   A, B   : unsigned operands, captured when start is accepted
//   busy   : high whenever the engine is not idle
//   done   : one-cycle pulse when Result/Steps are updated
//   Result : gcd(A,B) of the last completed computation
//   Steps  : subtractions used by the last computation, saturating at 16'hFFFF
module gcd_euclid #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [15:0]      Steps
);

   localparam int unsigned STEP_W = 16;
   localparam logic [STEP_W-1:0] STEP_MAX = '1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] MOD   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state, state_d;
   logic [WIDTH-1:0]  x, x_d;
   logic [WIDTH-1:0]  y, y_d;
   logic [WIDTH-1:0]  r, r_d;
   logic [STEP_W-1:0] step_cnt, step_cnt_d;
   logic [WIDTH-1:0]  result_d;
   logic [STEP_W-1:0] steps_d;
   logic              busy_d, done_d;

   // Next-state and datapath update
   always_comb begin
      state_d    = state;
      x_d        = x;
      y_d        = y;
      r_d        = r;
      step_cnt_d = step_cnt;
      result_d   = Result;
      steps_d    = Steps;

      case (state)
         IDLE: begin
            if (start) begin
               x_d        = A;
               y_d        = B;
               step_cnt_d = '0;
               state_d    = CHECK;
            end
         end
         CHECK: begin
            if (y == '0) begin
               result_d = x;
               steps_d  = step_cnt;
               state_d  = DONE;
            end else begin
               r_d     = x;
               state_d = MOD;
            end
         end
         MOD: begin
            // r = x mod y by repeated subtraction; the swap on r < y also
            // handles A < B on the first pass without a pre-swap.
            if (r >= y) begin
               r_d = r - y;
               if (step_cnt != STEP_MAX) begin
                  step_cnt_d = step_cnt + STEP_W'(1);
               end
            end else begin
               x_d     = y;
               y_d     = r;
               state_d = CHECK;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the upcoming state decode
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         x        <= '0;
         y        <= '0;
         r        <= '0;
         step_cnt <= '0;
         Result   <= '0;
         Steps    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         x        <= x_d;
         y        <= y_d;
         r        <= r_d;
         step_cnt <= step_cnt_d;
         Result   <= result_d;
         Steps    <= steps_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: doc/gcd_euclid.md
GCD_EUCLID -- requirements
Module: gcd_euclid

Interface
REQ-001 Parameter: WIDTH, 32, operand/result bit width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  first operand, unsigned; captured when start is accepted.
REQ-006 Port: B  input  WIDTH  second operand, unsigned; captured when start is accepted.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: done  output  1  one-cycle pulse, high only in state DONE.
REQ-009 Port: Result  output  WIDTH  registered gcd(A,B); holds until the next DONE.
REQ-010 Port: Steps  output  16  registered count of subtractions used by the last computation; saturates at 16'hFFFF.

Function
REQ-011 Internal registers SHALL be X, Y, R (WIDTH bits each) and a 16-bit step counter; X, Y, R SHALL NOT be visible as ports.
REQ-012 States SHALL be IDLE, CHECK, MOD, DONE; exactly one transition per clock edge.
REQ-013 IDLE: start=1 -> X<=A, Y<=B, step counter<=0, go to CHECK; start=0 -> stay; A/B ignored otherwise.
REQ-014 CHECK: Y==0 -> Result<=X, Steps<=step counter, go to DONE; else R<=X, go to MOD.
REQ-015 MOD: R>=Y -> R<=R-Y, step counter +1 (saturating), stay in MOD; R<Y -> X<=Y, Y<=R, go to CHECK.
REQ-016 Comparison and subtraction SHALL be unsigned WIDTH-bit; R-Y SHALL never underflow because it occurs only when R>=Y.
REQ-017 DONE: done=1 for exactly this cycle, go to IDLE unconditionally.
REQ-018 start asserted in any state other than IDLE SHALL be ignored with no effect on the computation in progress.
REQ-019 start held high continuously SHALL start a new computation on the first IDLE cycle after DONE, using A/B sampled at that edge.
REQ-020 Boundary gcd(x,0): Result=x. Boundary gcd(0,y): Result=y. Boundary gcd(0,0): Result=0. No error flag; no hang.
REQ-021 A<B SHALL need no pre-swap; the first MOD pass swaps naturally (R<Y on entry).
REQ-022 Result and Steps SHALL change only on the CHECK->DONE edge or on reset.

Reset
REQ-023 reset=0 at a rising edge SHALL force state IDLE, busy=0, done=0, Result=0, Steps=0, X=Y=R=0, step counter=0, regardless of current state.
REQ-024 Reset mid-computation SHALL abort the computation with no done pulse; the next start after reset release SHALL behave as from power-up.
REQ-025 A start asserted in the same cycle as reset=0 SHALL be ignored.

Verification
REQ-026 A=12, B=8, start pulse -> busy next cycle; done on the 9th cycle after the start edge; Result=4; Steps=3.
REQ-027 A=7, B=0 -> DONE two edges after start; Result=7; Steps=0. A=0, B=5 -> Result=5; Steps=0. A=0, B=0 -> Result=0.
REQ-028 A=8, B=12 (swap case) -> Result=4; Result matches A=12, B=8. A=32'hFFFFFFFF, B=1 -> Steps saturates at 16'hFFFF; Result=1; done still asserts.
REQ-029 Mid-run start with A=9, B=6 while busy computing gcd(12,8) -> ignored; Result=4; exactly one done pulse.
REQ-030 reset=0 during MOD of gcd(12,8) -> next cycle busy=0, Result=0, no done; then A=21, B=14, start -> Result=7.
REQ-031 Random unsigned A/B (1000 pairs, including zeros and equal values) -> Result equals a reference gcd; done pulses exactly once per accepted start; busy=0 only in IDLE.
